// File: rtl/alu_serial_ctrl_if.sv
// Bundles the request/response handshake and the 1-bit slice link of alu_serial_ctrl.
// The master modport belongs to the environment (requester plus ALU slice), and the slave modport belongs to the sequencer.
interface alu_serial_ctrl_if #(
   parameter int WIDTH = 8
);
   // Handshake: a request transfers on a rising edge where start=1 and ready=1.
   // start is ignored while ready=0, and nothing is queued.
   // done is a one-cycle pulse; result/carry/overflow/err are valid from that cycle until the next done.
   logic             start;
   logic             ready;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [2:0]       opcode;
   logic             slice_a;
   logic             slice_b;
   logic             slice_cin;
   logic [2:0]       slice_opcode;
   logic             slice_result;
   logic             slice_cout;
   logic [WIDTH-1:0] result;
   logic             carry;
   logic             overflow;
   logic             err;
   logic             done;
   logic [1:0]       dbg_state;

   modport master (
      output start, op_a, op_b, opcode, slice_result, slice_cout,
      input  ready, slice_a, slice_b, slice_cin, slice_opcode,
      input  result, carry, overflow, err, done, dbg_state
   );

   modport slave (
      input  start, op_a, op_b, opcode, slice_result, slice_cout,
      output ready, slice_a, slice_b, slice_cin, slice_opcode,
      output result, carry, overflow, err, done, dbg_state
   );
endinterface

// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer feeding one 1-bit ALU slice: it runs full-width ADD/AND/OR/NOT with LSB first.
// Defining ALU_SERIAL_SUB_EN adds opcode 100 = SUB (A-B), which uses the slice's ADD with B inverted and carry-in 1.
module alu_serial_ctrl #(
   parameter  int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH)
) (
   input logic              clk,
   input logic              rst_n,
   alu_serial_ctrl_if.slave bus
);
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [2:0] OP_ADD = 3'd0;
`ifdef ALU_SERIAL_SUB_EN
   localparam logic [2:0] OP_SUB = 3'd4;
`endif

   state_t             r_state;
   state_t             w_state_nxt;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [2:0]         r_op;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_cff;
   logic [WIDTH-1:0]   r_sh;
   logic [WIDTH-1:0]   r_result;
   logic               r_carry;
   logic               r_ovf;
   logic               r_err;

   logic               w_accept;
   logic               w_op_ok;
   logic               w_last;
   logic               w_run;
   logic               w_is_sub;
   logic               w_is_arith;
   logic [WIDTH-1:0]   w_sh_nxt;

   assign w_accept   = (r_state == S_IDLE) && bus.start;
   assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
   assign w_run      = (r_state == S_RUN);
`ifdef ALU_SERIAL_SUB_EN
   assign w_op_ok    = (bus.opcode <= 3'd4);
   assign w_is_sub   = (r_op == OP_SUB);
`else
   assign w_op_ok    = (bus.opcode <= 3'd3);
   assign w_is_sub   = 1'b0;
`endif
   assign w_is_arith = (r_op == OP_ADD) || w_is_sub;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // An unsupported opcode skips RUN entirely, so the slice never sees it.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_state_nxt = w_op_ok ? S_RUN : S_DONE;
         S_RUN:   if (w_last) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_sh_nxt        = r_sh;
      w_sh_nxt[r_cnt] = bus.slice_result;
   end

   // Slice drive comes only from latched operands and the counter; it is held at 0 outside RUN.
   assign bus.slice_a      = w_run & r_a[r_cnt];
   assign bus.slice_b      = w_run & (r_b[r_cnt] ^ w_is_sub);
   assign bus.slice_cin    = w_run & r_cff;
   assign bus.slice_opcode = w_run ? (w_is_sub ? OP_ADD : r_op) : 3'd0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a      <= '0;
         r_b      <= '0;
         r_op     <= '0;
         r_cnt    <= '0;
         r_cff    <= 1'b0;
         r_sh     <= '0;
         r_result <= '0;
         r_carry  <= 1'b0;
         r_ovf    <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_a   <= bus.op_a;
                  r_b   <= bus.op_b;
                  r_op  <= bus.opcode;
                  r_cnt <= '0;
                  r_sh  <= '0;
`ifdef ALU_SERIAL_SUB_EN
                  r_cff <= (bus.opcode == OP_SUB);
`else
                  r_cff <= 1'b0;
`endif
                  if (!w_op_ok) begin
                     r_result <= '0;
                     r_carry  <= 1'b0;
                     r_ovf    <= 1'b0;
                     r_err    <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               r_sh  <= w_sh_nxt;
               r_cff <= bus.slice_cout;
               // Signed overflow is the carry into the MSB XOR the carry out of it.
               if (w_last) begin
                  r_result <= w_sh_nxt;
                  r_carry  <= w_is_arith & bus.slice_cout;
                  r_ovf    <= w_is_arith & (r_cff ^ bus.slice_cout);
                  r_err    <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.ready     = (r_state == S_IDLE);
   assign bus.done      = (r_state == S_DONE);
   assign bus.result    = r_result;
   assign bus.carry     = r_carry;
   assign bus.overflow  = r_ovf;
   assign bus.err       = r_err;
   assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed bench for alu_serial_ctrl: it includes a behavioural slice, an arithmetic reference model with an expected queue,
// a per-cycle compare process and hand-computed literal checks.
module tb_alu_serial_ctrl;
  localparam int W = 8;
  localparam int PERIOD = 10;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail = 0;

  alu_serial_ctrl_if #(.WIDTH(W)) bus ();

  alu_serial_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #(PERIOD / 2) clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got timeout required finish");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // ---------------- behavioural 1-bit slice ----------------
  always_comb begin
    bus.slice_result = 1'b0;
    bus.slice_cout   = 1'b0;
    case (bus.slice_opcode)
      3'd0: begin
        bus.slice_result = bus.slice_a ^ bus.slice_b ^ bus.slice_cin;
        bus.slice_cout   = (bus.slice_a & bus.slice_b) | (bus.slice_cin & (bus.slice_a ^ bus.slice_b));
      end
      3'd1: bus.slice_result = bus.slice_a & bus.slice_b;
      3'd2: bus.slice_result = bus.slice_a | bus.slice_b;
      3'd3: bus.slice_result = ~bus.slice_a;
      default: ;
    endcase
  end

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Packed as {err, overflow, carry, result}.
  function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    int unsigned s;
    logic [W-1:0] r;
    logic c, v, e;
    r = '0; c = 1'b0; v = 1'b0; e = 1'b0;
    case (op)
      3'd0: begin
        s = int'(a) + int'(b);
        r = s[W-1:0];
        c = (s >= (1 << W));
        v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      3'd1: r = a & b;
      3'd2: r = a | b;
      3'd3: r = ~a;
`ifdef ALU_SERIAL_SUB_EN
      3'd4: begin
        r = a - b;
        c = (a >= b);
        v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
`endif
      default: e = 1'b1;
    endcase
    return {e, v, c, r};
  endfunction

  // Carry entering bit k: the carry out of the low k bits of the sum.
  function automatic logic carry_into(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op, input int k);
    int unsigned m;
    int unsigned bb;
    m  = (1 << k) - 1;
    bb = (op == 3'd4) ? int'(~b) : int'(b);
    if (op == 3'd4) return 1'(((int'(a) & m) + (bb & m) + 1) >> k);
    return 1'(((int'(a) & m) + (bb & m)) >> k);
  endfunction

  // ---------------- scoreboard ----------------
  logic [W+2:0] exp_q[$];
  logic [W-1:0] cur_a, cur_b;
  logic [2:0]   cur_op;
  int           k;

  always @(negedge clk) begin
    logic [W+2:0] e;
    if (!rst_n) begin
      k = 0;
    end else if (bus.done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'(bus.done), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("model_result", 32'({bus.err, bus.overflow, bus.carry, bus.result}), 32'(e));
      end
      k = 0;
    end else if (!bus.ready) begin
      if (k >= W) begin
        chk("run_too_long", 32'(k), 32'(W - 1));
      end else begin
        chk("slice_opcode", 32'(bus.slice_opcode), 32'((cur_op == 3'd4) ? 3'd0 : cur_op));
        chk("slice_a", 32'(bus.slice_a), 32'(cur_a[k]));
        chk("slice_b", 32'(bus.slice_b), 32'((cur_op == 3'd4) ? ~cur_b[k] : cur_b[k]));
        if (cur_op == 3'd0 || cur_op == 3'd4)
          chk("slice_cin", 32'(bus.slice_cin), 32'(carry_into(cur_a, cur_b, cur_op, k)));
      end
      k++;
    end else begin
      k = 0;
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                       input int pulse_at, input int abort_at,
                       output int lat, output longint t_acc, output bit aborted);
    int n;
    aborted = 1'b0;
    lat = 0;
    t_acc = 0;
    bus.op_a = a; bus.op_b = b; bus.opcode = op; bus.start = 1'b1;
    n = 0;
    while (!bus.ready && n < 100) begin @(negedge clk); n++; end
    if (!bus.ready) begin
      chk("accept_timeout", 32'(bus.ready), 32'd1);
      bus.start = 1'b0;
      return;
    end
    @(posedge clk);
    t_acc = longint'($time);
    exp_q.push_back(model(a, b, op));
    cur_a = a; cur_b = b; cur_op = op;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 100) begin
      if (lat == abort_at) begin
        rst_n = 1'b0;
        aborted = 1'b1;
        return;
      end
      if (lat == pulse_at) begin
        bus.start = 1'b1; bus.op_a = ~a; bus.opcode = 3'd1;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    if (!bus.done) chk("done_timeout", 32'(bus.done), 32'd1);
  endtask

  // Runs one operation and checks its latency and outputs against hand-computed literals.
  task automatic op_lit(input string name, input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                        input logic [W-1:0] r, input logic c, input logic v, input logic e, input int exp_lat);
    int lat; longint t; bit ab;
    issue(a, b, op, -1, -1, lat, t, ab);
    chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({name, "_result"}, 32'(bus.result), 32'(r));
    chk({name, "_carry"}, 32'(bus.carry), 32'(c));
    chk({name, "_overflow"}, 32'(bus.overflow), 32'(v));
    chk({name, "_err"}, 32'(bus.err), 32'(e));
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_ready"}, 32'(bus.ready), 32'd1);
    chk({name, "_done"}, 32'(bus.done), 32'd0);
    chk({name, "_outs"}, 32'({bus.result, bus.carry, bus.overflow, bus.err}), 32'd0);
    chk({name, "_slice"}, 32'({bus.slice_a, bus.slice_b, bus.slice_cin, bus.slice_opcode}), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat; longint t0, t1; bit ab;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.op_a = '0; bus.op_b = '0; bus.opcode = '0;
    cur_a = '0; cur_b = '0; cur_op = '0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    op_lit("add_35_4a", 8'h35, 8'h4A, 3'd0, 8'h7F, 1'b0, 1'b0, 1'b0, W + 1);
    op_lit("add_ff_01", 8'hFF, 8'h01, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0, W + 1);
    op_lit("add_7f_01", 8'h7F, 8'h01, 3'd0, 8'h80, 1'b0, 1'b1, 1'b0, W + 1);
    op_lit("and_f0_3c", 8'hF0, 8'h3C, 3'd1, 8'h30, 1'b0, 1'b0, 1'b0, W + 1);
    op_lit("or_f0_0c",  8'hF0, 8'h0C, 3'd2, 8'hFC, 1'b0, 1'b0, 1'b0, W + 1);
    op_lit("not_a5",    8'hA5, 8'h00, 3'd3, 8'h5A, 1'b0, 1'b0, 1'b0, W + 1);

    // A start pulse mid-run is ignored, and a follow-on request is held from the done cycle.
    issue(8'h12, 8'h34, 3'd0, 3, -1, lat, t0, ab);
    chk("midrun_result", 32'(bus.result), 32'h46);
    issue(8'h01, 8'h01, 3'd0, -1, -1, lat, t1, ab);
    chk("issue_spacing", 32'((t1 - t0) / PERIOD), 32'(W + 2));
    chk("b2b_result", 32'(bus.result), 32'h02);

    // Reset while bit 4 is on the slice.
    issue(8'h55, 8'h0F, 3'd0, -1, 5, lat, t0, ab);
    chk("abort_taken", 32'(ab), 32'd1);
    #1;
    chk_reset_outputs("midrun_reset");
    exp_q.delete();
    repeat (3) begin
      @(negedge clk);
      chk("reset_no_done", 32'(bus.done), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    op_lit("add_01_02", 8'h01, 8'h02, 3'd0, 8'h03, 1'b0, 1'b0, 1'b0, W + 1);

    op_lit("op_110", 8'h33, 8'h44, 3'd6, 8'h00, 1'b0, 1'b0, 1'b1, 1);
    // Results hold after done until the next request completes.
    @(negedge clk);
    chk("err_hold", 32'({bus.err, bus.result}), 32'h100);
`ifdef ALU_SERIAL_SUB_EN
    op_lit("sub_05_07", 8'h05, 8'h07, 3'd4, 8'hFE, 1'b0, 1'b0, 1'b0, W + 1);
    op_lit("sub_80_01", 8'h80, 8'h01, 3'd4, 8'h7F, 1'b1, 1'b1, 1'b0, W + 1);
`else
    op_lit("op_100", 8'h05, 8'h07, 3'd4, 8'h00, 1'b0, 1'b0, 1'b1, 1);
`endif
    op_lit("op_111", 8'h01, 8'h01, 3'd7, 8'h00, 1'b0, 1'b0, 1'b1, 1);
    op_lit("add_after_err", 8'h80, 8'h80, 3'd0, 8'h00, 1'b1, 1'b1, 1'b0, W + 1);

    repeat (2) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
